// File: rtl/rv32_cpu_core.sv
// rv32_cpu_core: multi-cycle RV32I-subset core; one instruction in flight (fetch, exec, optional mem, writeback).
// All requests on the shared native port are held until mem_ready, so wait states simply stall the FSM.
module rv32_cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_next_pc;
    logic [31:0] r_wb_val;
    logic        r_wb_en;
    logic [31:0] r_regs [0:31];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_sra;
    logic        w_sub;
    logic        w_lt;
    logic        w_ltu;
    logic        w_br_lt;
    logic        w_br_ltu;
    logic        w_alu_ok;
    logic        w_take;
    logic [31:0] w_alu;
    logic [31:0] w_sum_addr;
    logic [31:0] w_eff_addr;
    logic [31:0] w_wb_val;
    logic [31:0] w_next_pc;
    logic        w_wb_en;
    logic        w_is_lw;
    logic        w_is_sw;

    assign w_opcode  = r_instr[6:0];
    assign w_rd      = r_instr[11:7];
    assign w_f3      = r_instr[14:12];
    assign w_rs1     = r_instr[19:15];
    assign w_rs2     = r_instr[24:20];
    assign w_f7      = r_instr[31:25];
    assign w_imm_i   = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s   = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b   = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_u   = {r_instr[31:12], 12'b0};
    assign w_imm_j   = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

    // x0 is never written, so a plain array read already returns zero for it
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];

    assign w_op_b    = (w_opcode == OP_REG) ? w_rs2_val : w_imm_i;
    assign w_shamt   = w_op_b[4:0];
    assign w_sra     = $signed(w_rs1_val) >>> w_shamt;
    assign w_sub     = (w_opcode == OP_REG) && w_f7[5];
    assign w_lt      = $signed(w_rs1_val) < $signed(w_op_b);
    assign w_ltu     = w_rs1_val < w_op_b;
    assign w_br_lt   = $signed(w_rs1_val) < $signed(w_rs2_val);
    assign w_br_ltu  = w_rs1_val < w_rs2_val;

    assign w_sum_addr = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
    assign w_eff_addr = {w_sum_addr[31:2], 2'b00};

    always_comb begin
        w_alu_ok = 1'b1;
        if (w_opcode == OP_REG)
            w_alu_ok = (w_f7 == 7'b0000000) ||
                       (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
        else if (w_f3 == 3'b001)
            w_alu_ok = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'b101)
            w_alu_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
    end

    always_comb begin
        w_alu = 32'h0;
        case (w_f3)
            3'b000:  w_alu = w_sub ? (w_rs1_val - w_op_b) : (w_rs1_val + w_op_b);
            3'b001:  w_alu = w_rs1_val << w_shamt;
            3'b010:  w_alu = {31'b0, w_lt};
            3'b011:  w_alu = {31'b0, w_ltu};
            3'b100:  w_alu = w_rs1_val ^ w_op_b;
            3'b101:  w_alu = w_f7[5] ? w_sra : (w_rs1_val >> w_shamt);
            3'b110:  w_alu = w_rs1_val | w_op_b;
            default: w_alu = w_rs1_val & w_op_b;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        case (w_f3)
            3'b000:  w_take = (w_rs1_val == w_rs2_val);
            3'b001:  w_take = (w_rs1_val != w_rs2_val);
            3'b100:  w_take = w_br_lt;
            3'b101:  w_take = !w_br_lt;
            3'b110:  w_take = w_br_ltu;
            3'b111:  w_take = !w_br_ltu;
            default: w_take = 1'b0;
        endcase
    end

    // Anything not matched below falls through as a NOP: pc + 4, no writes
    always_comb begin
        w_wb_en   = 1'b0;
        w_wb_val  = w_alu;
        w_next_pc = r_pc + 32'd4;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
        case (w_opcode)
            OP_LUI:    begin w_wb_en = 1'b1; w_wb_val = w_imm_u; end
            OP_AUIPC:  begin w_wb_en = 1'b1; w_wb_val = r_pc + w_imm_u; end
            OP_JAL: begin
                w_wb_en   = 1'b1;
                w_wb_val  = r_pc + 32'd4;
                w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR: begin
                if (w_f3 == 3'b000) begin
                    w_wb_en   = 1'b1;
                    w_wb_val  = r_pc + 32'd4;
                    w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: if (w_take) w_next_pc = r_pc + w_imm_b;
            OP_LOAD:   if (w_f3 == 3'b010) begin w_is_lw = 1'b1; w_wb_en = 1'b1; end
            OP_STORE:  if (w_f3 == 3'b010) w_is_sw = 1'b1;
            OP_IMM, OP_REG: w_wb_en = w_alu_ok;
            default: ;
        endcase
        if (w_rd == 5'd0)
            w_wb_en = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0;
            r_next_pc <= RESET_PC;
            r_wb_val  <= 32'h0;
            r_wb_en   <= 1'b0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    mem_valid <= 1'b1;
                    mem_instr <= 1'b1;
                    mem_addr  <= r_pc;
                    mem_wstrb <= 4'b0000;
                    r_state   <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_instr   <= mem_rdata;
                        mem_valid <= 1'b0;
                        mem_instr <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_wb_en   <= w_wb_en;
                    r_wb_val  <= w_wb_val;
                    r_next_pc <= w_next_pc;
                    if (w_is_lw || w_is_sw) begin
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b0;
                        mem_addr  <= w_eff_addr;
                        mem_wdata <= w_rs2_val;
                        mem_wstrb <= w_is_sw ? 4'b1111 : 4'b0000;
                        r_state   <= S_MEM;
                    end else begin
                        r_state   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (mem_wstrb == 4'b0000)
                            r_wb_val <= mem_rdata;
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        r_state   <= S_WB;
                    end
                end
                S_WB: begin
                    // Retire and issue the next fetch on the same edge
                    if (r_wb_en)
                        r_regs[w_rd] <= r_wb_val;
                    r_pc      <= r_next_pc;
                    mem_valid <= 1'b1;
                    mem_instr <= 1'b1;
                    mem_addr  <= r_next_pc;
                    mem_wstrb <= 4'b0000;
                    r_state   <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_cpu_core.sv
// Bench for rv32_cpu_core: RAM responder with random wait states, ALU vector table,
// directed program sequences and random programs checked against an ISA-level model.
module tb_rv32_cpu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;

    rv32_cpu_core #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mem   [0:1023];
    logic [31:0] m_mem [0:1023];
    logic [31:0] m_x   [0:31];
    int  max_wait = 0;
    bit  stall = 0;
    bit  done_seen = 0;
    int  hs_err = 0;
    int  fetch_cnt = 0;
    logic [31:0] last_fetch = 32'h0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[25];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, rs, input logic [11:0] imm);
        return enc_i(imm, rs, 3'd0, rd, 7'h13);
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, base, input logic [11:0] off);
        return enc_s(off, rs2, base);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, base, input logic [11:0] off);
        return enc_i(off, base, 3'd2, rd, 7'h03);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt, input logic [31:0] a, b);
        logic [4:0] s;
        s = b[4:0];
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << s;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? ((a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0)) : (a >> s);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Instruction-level interpreter: runs until the store to the 0x7FC done marker
    function automatic void model_run();
        logic [31:0] pc, pc_n, ins, a, b, r, ea, ii, si, bi, ji;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit wr, ok, stop;
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
        pc = 32'h0;
        stop = 0;
        for (int n = 0; n < 4000 && !stop; n++) begin
            ins = m_mem[pc[11:2]];
            f3 = ins[14:12]; f7 = ins[31:25];
            a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
            ii = {{20{ins[31]}}, ins[31:20]};
            si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            wr = 0; r = 32'h0; pc_n = pc + 4;
            case (ins[6:0])
                7'h37: begin wr = 1; r = {ins[31:12], 12'h0}; end
                7'h17: begin wr = 1; r = pc + {ins[31:12], 12'h0}; end
                7'h6F: begin wr = 1; r = pc + 4; pc_n = pc + ji; end
                7'h67: if (f3 == 0) begin wr = 1; r = pc + 4; pc_n = (a + ii) & 32'hFFFF_FFFE; end
                7'h63: begin
                    case (f3)
                        3'd0: ok = (a == b);
                        3'd1: ok = (a != b);
                        3'd4: ok = ($signed(a) < $signed(b));
                        3'd5: ok = ($signed(a) >= $signed(b));
                        3'd6: ok = (a < b);
                        3'd7: ok = (a >= b);
                        default: ok = 0;
                    endcase
                    if (ok) pc_n = pc + bi;
                end
                7'h03: if (f3 == 2) begin ea = a + ii; wr = 1; r = m_mem[ea[11:2]]; end
                7'h23: if (f3 == 2) begin
                    ea = a + si;
                    m_mem[ea[11:2]] = b;
                    if (ea[11:2] == 10'h1FF) stop = 1;
                end
                7'h13: begin
                    ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                    if (ok) begin wr = 1; r = ref_alu(f3, f3 == 5 && f7 == 7'h20, a, ii); end
                end
                7'h33: begin
                    ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                    if (ok) begin wr = 1; r = ref_alu(f3, f7 == 7'h20, a, b); end
                end
                default: ;
            endcase
            if (wr && ins[11:7] != 0) m_x[ins[11:7]] = r;
            pc = pc_n;
        end
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic put(input int unsigned addr, input logic [31:0] w);
        mem[addr[11:2]] = w;
        m_mem[addr[11:2]] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin mem[i] = 32'h0; m_mem[i] = 32'h0; end
    endtask

    task automatic put_li(input int unsigned addr, input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] hi;
        hi = (v + 32'h800) >> 12;
        put(addr, {hi[19:0], rd, 7'h37});
        put(addr + 4, addi(rd, rd, v[11:0]));
    endtask

    // Memory responder: random wait states, write on acceptance, handshake rule checks
    task automatic responder();
        int cnt;
        bit pend, acc_prev;
        logic [31:0] q_addr, q_wdata;
        logic [3:0]  q_wstrb;
        logic        q_instr;
        pend = 0; cnt = 0; acc_prev = 0;
        q_addr = 0; q_wdata = 0; q_wstrb = 0; q_instr = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (acc_prev && mem_valid && !reset) hs_err++;
            acc_prev = 0;
            if (reset || !mem_valid) begin
                pend = 0;
            end else begin
                if (!pend) begin
                    pend = 1;
                    cnt = $urandom_range(0, max_wait);
                    q_addr = mem_addr; q_wdata = mem_wdata; q_wstrb = mem_wstrb; q_instr = mem_instr;
                end else if (mem_addr !== q_addr || mem_wstrb !== q_wstrb || mem_instr !== q_instr ||
                             (q_wstrb != 0 && mem_wdata !== q_wdata)) begin
                    hs_err++;
                end
                if (!stall) begin
                    if (cnt == 0) begin
                        mem_ready = 1'b1;
                        pend = 0;
                        acc_prev = 1;
                        if (mem_addr[1:0] != 2'b00) hs_err++;
                        if (mem_wstrb == 4'hF) begin
                            mem[mem_addr[11:2]] = mem_wdata;
                            if (mem_addr[11:0] == 12'h7FC) done_seen = 1;
                        end else if (mem_wstrb != 4'h0) begin
                            hs_err++;
                        end
                        mem_rdata = mem[mem_addr[11:2]];
                        if (mem_instr) begin last_fetch = mem_addr; fetch_cnt++; end
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    endtask

    task automatic start_core();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        done_seen = 0;
        hs_err = 0;
        reset = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        cyc = 0;
        while (!done_seen && cyc < 3000) begin @(posedge clk); cyc++; end
        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("FAIL %s: done marker not written after %0d cycles, required within 3000", nm, cyc);
        end
        repeat (4) @(posedge clk);
        check({nm, " handshake"}, hs_err, 0);
    endtask

    task automatic load_chain();
        clear_mem();
        put(0,  addi(1, 0, 12'd10));
        put(4,  enc_r(7'h0, 1, 1, 3'd0, 2, 7'h33));
        put(8,  enc_r(7'h0, 2, 1, 3'd0, 3, 7'h33));
        put(12, sw(3, 0, 12'h080));
        put(16, lw(4, 0, 12'h080));
        put(20, sw(4, 0, 12'h084));
        put(24, sw(0, 0, 12'h7FC));
        put(28, 32'h0000_006F);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, r1, r2;
        logic [2:0] f3;
        logic [11:0] imm;
        logic [2:0] bf [7];
        bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
        rd = 5'($urandom_range(0, 8)); r1 = 5'($urandom_range(0, 8)); r2 = 5'($urandom_range(0, 8));
        f3 = 3'($urandom_range(0, 7));
        imm = 12'($urandom_range(0, 4095));
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                if ($urandom_range(0, 9) == 0) return enc_r(7'h01, r2, r1, f3, rd, 7'h33);
                return enc_r((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'h33);
            end
            4, 5, 6: begin
                if (f3 == 1) imm[11:5] = ($urandom_range(0, 9) == 0) ? 7'h20 : 7'h00;
                if (f3 == 5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_i(imm, r1, f3, rd, 7'h13);
            end
            7: return enc_b(13'd8, ($urandom_range(0, 3) == 0) ? r1 : r2, r1, bf[$urandom_range(0, 6)]);
            8: return lw(rd, 0, 12'(32'h400 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)));
            default: return sw(r2, 0, 12'(32'h400 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)));
        endcase
    endfunction

    initial begin
        int unsigned p;
        bit seen;
        fork
            responder();
            begin
                #900000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        tbl[0]  = '{enc_r(7'h00, 2, 1, 3'd0, 3, 7'h33), 32'd5,          32'd7,          32'd12};
        tbl[1]  = '{enc_r(7'h20, 2, 1, 3'd0, 3, 7'h33), 32'd5,          32'd7,          32'hFFFF_FFFE};
        tbl[2]  = '{enc_r(7'h00, 2, 1, 3'd1, 3, 7'h33), 32'd1,          32'd33,         32'd2};
        tbl[3]  = '{enc_r(7'h00, 2, 1, 3'd2, 3, 7'h33), 32'hFFFF_FFFF,  32'd1,          32'd1};
        tbl[4]  = '{enc_r(7'h00, 2, 1, 3'd3, 3, 7'h33), 32'hFFFF_FFFF,  32'd1,          32'd0};
        tbl[5]  = '{enc_r(7'h00, 2, 1, 3'd4, 3, 7'h33), 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00};
        tbl[6]  = '{enc_r(7'h00, 2, 1, 3'd5, 3, 7'h33), 32'h8000_0000,  32'd4,          32'h0800_0000};
        tbl[7]  = '{enc_r(7'h20, 2, 1, 3'd5, 3, 7'h33), 32'h8000_0000,  32'd4,          32'hF800_0000};
        tbl[8]  = '{enc_r(7'h00, 2, 1, 3'd6, 3, 7'h33), 32'h00FF_00FF,  32'h0F0F_0F0F,  32'h0FFF_0FFF};
        tbl[9]  = '{enc_r(7'h00, 2, 1, 3'd7, 3, 7'h33), 32'h00FF_00FF,  32'h0F0F_0F0F,  32'h000F_000F};
        tbl[10] = '{enc_i(12'hFFF, 1, 3'd0, 3, 7'h13),  32'd0,          32'd0,          32'hFFFF_FFFF};
        tbl[11] = '{enc_i(12'hFFF, 1, 3'd2, 3, 7'h13),  32'hFFFF_FFFE,  32'd0,          32'd1};
        tbl[12] = '{enc_i(12'hFFF, 1, 3'd3, 3, 7'h13),  32'd5,          32'd0,          32'd1};
        tbl[13] = '{enc_i(12'h7FF, 1, 3'd4, 3, 7'h13),  32'hFFFF_FFFF,  32'd0,          32'hFFFF_F800};
        tbl[14] = '{enc_i(12'h800, 1, 3'd6, 3, 7'h13),  32'h0000_000F,  32'd0,          32'hFFFF_F80F};
        tbl[15] = '{enc_i(12'h0F0, 1, 3'd7, 3, 7'h13),  32'h1234_5678,  32'd0,          32'h0000_0070};
        tbl[16] = '{enc_i(12'h01F, 1, 3'd1, 3, 7'h13),  32'd3,          32'd0,          32'h8000_0000};
        tbl[17] = '{enc_i(12'h01F, 1, 3'd5, 3, 7'h13),  32'h8000_0000,  32'd0,          32'd1};
        tbl[18] = '{enc_i(12'h41F, 1, 3'd5, 3, 7'h13),  32'h8000_0000,  32'd0,          32'hFFFF_FFFF};
        tbl[19] = '{enc_r(7'h01, 2, 1, 3'd0, 3, 7'h33), 32'd5,          32'd7,          32'd0};
        tbl[20] = '{enc_i(12'h401, 1, 3'd1, 3, 7'h13),  32'd5,          32'd0,          32'd0};
        tbl[21] = '{{20'hABCDE, 5'd3, 7'h37},           32'd0,          32'd0,          32'hABCD_E000};
        tbl[22] = '{{20'h00001, 5'd3, 7'h17},           32'd0,          32'd0,          32'h0000_1010};
        tbl[23] = '{enc_r(7'h00, 2, 1, 3'd0, 0, 7'h33), 32'd5,          32'd7,          32'd0};
        tbl[24] = '{32'h0000_0000,                      32'd9,          32'd9,          32'd0};

        // Reset state of the memory port while reset is held
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_valid", {31'b0, mem_valid}, 32'd0);
        check("reset mem_instr", {31'b0, mem_instr}, 32'd0);
        check("reset mem_addr",  mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset mem_wstrb", {28'b0, mem_wstrb}, 32'd0);

        foreach (tbl[i]) begin
            clear_mem();
            put_li(0, 1, tbl[i].a);
            put_li(8, 2, tbl[i].b);
            put(16, tbl[i].ins);
            put(20, sw(3, 0, 12'h080));
            put(24, sw(0, 0, 12'h7FC));
            put(28, 32'h0000_006F);
            max_wait = i % 4;
            start_core();
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d result", i), mem[32], tbl[i].exp);
        end

        for (int w = 0; w < 4; w += 3) begin
            load_chain();
            max_wait = w;
            start_core();
            wait_done("chain");
            check($sformatf("chain w%0d mem80", w), mem[32], 32'd30);
            check($sformatf("chain w%0d mem84", w), mem[33], 32'd30);
        end

        clear_mem();
        put(0,  addi(5, 0, 12'd42));
        put(4,  addi(6, 0, 12'd42));
        put(8,  enc_b(13'd8, 6, 5, 3'd0));
        put(12, 32'h0000_006F);
        put(16, sw(5, 0, 12'h088));
        put(20, sw(0, 0, 12'h7FC));
        put(24, 32'h0000_006F);
        max_wait = 2;
        start_core();
        wait_done("branch");
        check("branch mem88", mem[34], 32'd42);

        clear_mem();
        put(0,  {20'h12345, 5'd7, 7'h37});
        put(4,  sw(7, 0, 12'h08C));
        put(8,  enc_i(12'h678, 7, 3'd6, 7, 7'h13));
        put(12, sw(7, 0, 12'h090));
        put(16, sw(0, 0, 12'h7FC));
        put(20, 32'h0000_006F);
        max_wait = 1;
        start_core();
        wait_done("upper");
        check("upper mem8C", mem[35], 32'h1234_5000);
        check("upper mem90", mem[36], 32'h1234_5678);

        // Call/return with an odd JALR offset; core must end spinning at 16
        clear_mem();
        put(0,  addi(10, 0, 12'd100));
        put(4,  enc_j(21'd16, 1));
        put(8,  sw(10, 0, 12'h094));
        put(12, sw(0, 0, 12'h7FC));
        put(16, 32'h0000_006F);
        put(20, addi(5, 10, 12'd0));
        put(24, enc_r(7'h00, 5, 5, 3'd0, 10, 7'h33));
        put(28, enc_i(12'd1, 1, 3'd0, 0, 7'h67));
        max_wait = 3;
        start_core();
        wait_done("call");
        check("call mem94", mem[37], 32'd200);
        p = fetch_cnt;
        repeat (40) @(posedge clk);
        check("call spin pc", last_fetch, 32'd16);
        check("call spin active", {31'b0, fetch_cnt > p}, 32'd1);

        clear_mem();
        put(0,  addi(1, 0, 12'h082));
        put(4,  addi(2, 0, 12'd77));
        put(8,  sw(2, 1, 12'd1));
        put(12, lw(3, 1, 12'hFFF));
        put(16, sw(3, 0, 12'h084));
        put(20, sw(0, 0, 12'h7FC));
        put(24, 32'h0000_006F);
        max_wait = 0;
        start_core();
        wait_done("misalign");
        check("misalign mem80", mem[32], 32'd77);
        check("misalign mem84", mem[33], 32'd77);

        // Reset while a fetch at 0x0C is stalled
        load_chain();
        max_wait = 0;
        start_core();
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            if (mem_valid && mem_instr && mem_addr == 32'd12) begin seen = 1; stall = 1; end
        end
        check("midfetch reached", {31'b0, seen}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midfetch valid drop", {31'b0, mem_valid}, 32'd0);
        check("midfetch addr clr", mem_addr, 32'd0);
        check("midfetch mem80 untouched", mem[32], 32'd0);
        stall = 0;
        @(negedge clk);
        done_seen = 0;
        hs_err = 0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("refetch valid", {31'b0, mem_valid}, 32'd1);
        check("refetch instr", {31'b0, mem_instr}, 32'd1);
        check("refetch addr", mem_addr, 32'd0);
        wait_done("midfetch");
        check("midfetch mem80", mem[32], 32'd30);
        check("midfetch mem84", mem[33], 32'd30);

        for (int t = 0; t < 10; t++) begin
            clear_mem();
            for (int k = 0; k < 16; k++) put(32'h400 + 4 * k, $urandom);
            p = 0;
            for (int r = 1; r <= 8; r++) begin put_li(p, 5'(r), $urandom); p += 8; end
            for (int k = 0; k < 24; k++) begin put(p, rand_instr()); p += 4; end
            for (int r = 1; r <= 8; r++) begin put(p, sw(5'(r), 0, 12'(32'h500 + 4 * (r - 1)))); p += 4; end
            put(p, sw(0, 0, 12'h7FC));
            put(p + 4, 32'h0000_006F);
            model_run();
            max_wait = $urandom_range(0, 3);
            start_core();
            wait_done($sformatf("rand%0d", t));
            for (int k = 0; k < 16; k++)
                check($sformatf("rand%0d data%0d", t, k), mem[256 + k], m_mem[256 + k]);
            for (int k = 0; k < 8; k++)
                check($sformatf("rand%0d x%0d", t, k + 1), mem[320 + k], m_mem[320 + k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
